// File: rtl/layer_sequencer.sv
// Walks a software-written descriptor table of conv layers: weight-load handshake, then compute handshake, per layer.
// Define LAYER_SEQ_TIMEOUT_EN to bound both handshake waits and expose a sticky timeout flag.
module layer_sequencer #(
  parameter int MAX_LAYERS = 16,
  parameter int IDX_W      = 4,
  parameter int DESC_W     = 32
`ifdef LAYER_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 32'd1048576
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [IDX_W-1:0]  cfg_wr_idx,
  input  logic [DESC_W-1:0] cfg_wr_data,
  input  logic [IDX_W:0]    num_layers,
  input  logic              start,
  input  logic              abort,
  input  logic              write_weight_finish,
  input  logic              layer_finish,
  output logic              weight_load_req,
  output logic              layer_start,
  output logic [1:0]        operation,
  output logic [4:0]        kernel_size,
  output logic [11:0]       input_channel_size,
  output logic [11:0]       output_channel_size,
  output logic [IDX_W-1:0]  cur_layer,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef LAYER_SEQ_TIMEOUT_EN
  , output logic            timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WLOAD, S_WWAIT, S_RUN, S_RWAIT, S_NEXT
  } state_e;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LAYERS);

  state_e              state_q, state_d;
  logic [DESC_W-1:0]   desc_mem [MAX_LAYERS];
  logic [IDX_W:0]      count_q, count_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [1:0]          op_q;
  logic [4:0]          ksize_q;
  logic [11:0]         ich_q, och_q;
  logic [IDX_W:0]      num_clamped;
  logic                start_ok, abort_ok, wait_expired, last_layer;
  logic                rsvd_unused;

  // The reserved descriptor bit is stored but has no consumer.
  assign rsvd_unused = ^cfg_wr_data[DESC_W-1:31];

  assign start_ok    = (state_q == S_IDLE) && start;
  assign abort_ok    = (state_q != S_IDLE) && (abort || wait_expired);
  assign num_clamped = (num_layers > MAX_CNT) ? MAX_CNT : num_layers;
  assign last_layer  = ({1'b0, cur_q} == (count_q - 1'b1));

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        timeout_q, timeout_d;

  // Counter restarts in the single cycle that precedes each wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WLOAD || state_q == S_RUN) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WWAIT || state_q == S_RWAIT) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign wait_expired = (wait_cnt_q == (TIMEOUT_CYCLES - 32'd1)) &&
                        ((state_q == S_WWAIT && !write_weight_finish) ||
                         (state_q == S_RWAIT && !layer_finish));
  assign timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
`endif

  // Descriptor table: writable only while idle, never reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && state_q == S_IDLE) begin
      desc_mem[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      ksize_q <= '0;
      ich_q   <= '0;
      och_q   <= '0;
    end else if (state_q == S_FETCH) begin
      {och_q, ich_q, ksize_q, op_q} <= desc_mem[cur_q][30:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      cur_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cur_q     <= cur_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && num_layers != '0) state_d = S_FETCH;
      S_FETCH: state_d = S_WLOAD;
      S_WLOAD: state_d = S_WWAIT;
      S_WWAIT: if (write_weight_finish) state_d = S_RUN;
      S_RUN:   state_d = S_RWAIT;
      S_RWAIT: if (layer_finish) state_d = S_NEXT;
      S_NEXT:  state_d = last_layer ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (abort_ok) state_d = S_IDLE;
  end

  always_comb begin
    count_d   = count_q;
    cur_d     = cur_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    if (start_ok) begin
      aborted_d = 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      if (num_layers == '0) begin
        done_d = 1'b1;
      end else begin
        count_d = num_clamped;
        cur_d   = '0;
      end
    end
    if (state_q == S_NEXT && !abort_ok) begin
      if (last_layer) done_d = 1'b1;
      else            cur_d  = cur_q + 1'b1;
    end
    // An expired wait reports as timeout rather than abort.
    if (abort_ok) begin
`ifdef LAYER_SEQ_TIMEOUT_EN
      if (wait_expired) timeout_d = 1'b1;
      else              aborted_d = 1'b1;
`else
      aborted_d = 1'b1;
`endif
    end
  end

  always_comb begin
    weight_load_req = (state_q == S_WLOAD);
    layer_start     = (state_q == S_RUN);
    busy            = (state_q != S_IDLE);
  end

  assign operation           = op_q;
  assign kernel_size         = ksize_q;
  assign input_channel_size  = ich_q;
  assign output_channel_size = och_q;
  assign cur_layer           = cur_q;
  assign done                = done_q;
  assign aborted             = aborted_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer; define LAYER_SEQ_TIMEOUT_EN to exercise the bounded-wait build.
module tb_layer_sequencer;
  localparam int MAX_LAYERS = 16;
  localparam int IDX_W = 4;

  logic        clk = 1'b0;
  logic        rst, cfg_wr_en, start, abort, write_weight_finish, layer_finish;
  logic [3:0]  cfg_wr_idx;
  logic [31:0] cfg_wr_data;
  logic [4:0]  num_layers;
  logic        weight_load_req, layer_start, busy, done, aborted;
  logic [1:0]  operation;
  logic [4:0]  kernel_size;
  logic [11:0] input_channel_size, output_channel_size;
  logic [3:0]  cur_layer;

  always #5 clk = ~clk;

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic timeout;
  layer_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_data(cfg_wr_data), .num_layers(num_layers), .start(start), .abort(abort),
    .write_weight_finish(write_weight_finish), .layer_finish(layer_finish),
    .weight_load_req(weight_load_req), .layer_start(layer_start), .operation(operation),
    .kernel_size(kernel_size), .input_channel_size(input_channel_size),
    .output_channel_size(output_channel_size), .cur_layer(cur_layer), .busy(busy),
    .done(done), .aborted(aborted), .timeout(timeout));
`else
  layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_data(cfg_wr_data), .num_layers(num_layers), .start(start), .abort(abort),
    .write_weight_finish(write_weight_finish), .layer_finish(layer_finish),
    .weight_load_req(weight_load_req), .layer_start(layer_start), .operation(operation),
    .kernel_size(kernel_size), .input_channel_size(input_channel_size),
    .output_channel_size(output_channel_size), .cur_layer(cur_layer), .busy(busy),
    .done(done), .aborted(aborted));
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] d0, d1, d2, d3, d1_new;
  logic [30:0] rec_fields [MAX_LAYERS];
  logic [3:0]  rec_cur    [MAX_LAYERS];
  int          n_wl, n_ls, n_done;
  logic        busy_at_done, seq_ended;

  function automatic logic [31:0] mk_desc(input int op, input int k, input int ic, input int oc);
    return {1'b0, 12'(oc), 12'(ic), 5'(k), 2'(op)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_desc(input logic [3:0] idx, input logic [31:0] data);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_data = data;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    num_layers = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Upstream model: each finish returned 'delay' cycles after its request pulse.
  task automatic run_seq(input int delay, input int abort_layer, input int wr_layer,
                         input logic [3:0] wr_idx, input logic [31:0] wr_data);
    int wt, rt;
    logic pend_abort, pend_wr;
    wt = -1; rt = -1; pend_abort = 1'b0; pend_wr = 1'b0;
    n_wl = 0; n_ls = 0; n_done = 0; seq_ended = 1'b0; busy_at_done = 1'b1;
    for (int c = 0; c < 2000 && !seq_ended; c++) begin
      write_weight_finish = 1'b0; layer_finish = 1'b0; cfg_wr_en = 1'b0; abort = 1'b0;
      if (wt > 0) begin wt--; if (wt == 0) begin write_weight_finish = 1'b1; wt = -1; end end
      if (rt > 0) begin rt--; if (rt == 0) begin layer_finish = 1'b1; rt = -1; end end
      if (pend_wr) begin
        cfg_wr_en = 1'b1; cfg_wr_idx = wr_idx; cfg_wr_data = wr_data; pend_wr = 1'b0;
      end
      if (pend_abort) begin abort = 1'b1; seq_ended = 1'b1; end
      if (weight_load_req) begin n_wl++; wt = delay; end
      if (layer_start) begin
        $display("layer_start layer=%0d op=%0d k=%0d ic=%0d oc=%0d", cur_layer, operation,
                 kernel_size, input_channel_size, output_channel_size);
        if (n_ls < MAX_LAYERS) begin
          rec_fields[n_ls] = {output_channel_size, input_channel_size, kernel_size, operation};
          rec_cur[n_ls] = cur_layer;
        end
        n_ls++; rt = delay;
        if (int'(cur_layer) == wr_layer) pend_wr = 1'b1;
        if (int'(cur_layer) == abort_layer) pend_abort = 1'b1;
      end
      if (done) begin n_done++; busy_at_done = busy; seq_ended = 1'b1; end
      if (!seq_ended) step();
    end
    checks++;
    if (!seq_ended) begin
      errors++; $display("FAIL run_seq_bound: sequence did not end within 2000 cycles");
    end
    write_weight_finish = 1'b0; layer_finish = 1'b0; cfg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, aborted, weight_load_req, layer_start} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {busy, done, aborted, weight_load_req, layer_start});
    end
    checks++;
    if ({cur_layer, operation, kernel_size, input_channel_size, output_channel_size} !== '0) begin
      errors++; $display("FAIL reset_fields: got cur=%0d op=%0d k=%0d ic=%0d oc=%0d want all 0",
                         cur_layer, operation, kernel_size, input_channel_size, output_channel_size);
    end
`ifdef LAYER_SEQ_TIMEOUT_EN
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int extra_done;
    write_desc(4'd0, d0); write_desc(4'd1, d1); write_desc(4'd2, d2);
    pulse_start(5'd3);
    run_seq(5, -1, -1, 4'd0, 32'd0);
    checks++;
    if (n_wl !== 3) begin errors++; $display("FAIL basic_wl_pulses: got %0d want 3", n_wl); end
    checks++;
    if (n_ls !== 3) begin errors++; $display("FAIL basic_ls_pulses: got %0d want 3", n_ls); end
    checks++;
    if (n_done !== 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done=%0d busy=%b want 1 / 0", n_done, busy_at_done);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_d;
      exp_d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      checks++;
      if (rec_fields[i] !== exp_d[30:0]) begin
        errors++; $display("FAIL basic_fields%0d: got %h want %h", i, rec_fields[i], exp_d[30:0]);
      end
      checks++;
      if (rec_cur[i] !== 4'(i)) begin
        errors++; $display("FAIL basic_cur%0d: got %0d want %0d", i, rec_cur[i], i);
      end
    end
    extra_done = 0;
    repeat (3) begin step(); if (done) extra_done++; end
    checks++;
    if (extra_done !== 0) begin errors++; $display("FAIL basic_done_once: got %0d extra want 0", extra_done); end
  endtask

  task automatic test_zero_layers();
    int bad;
    pulse_start(5'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b busy=%b want 1 / 0", done, busy);
    end
    bad = 0;
    repeat (5) begin step(); if (busy || done || weight_load_req || layer_start) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL zero_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_write_while_busy();
    pulse_start(5'd2);
    run_seq(3, -1, 0, 4'd1, d1_new);
    checks++;
    if (n_ls !== 2 || rec_fields[1] !== d1[30:0]) begin
      errors++; $display("FAIL busy_write_ignored: got n_ls=%0d fields=%h want 2 / %h",
                         n_ls, rec_fields[1], d1[30:0]);
    end
    step();
  endtask

  task automatic test_abort();
    int bad;
    write_desc(4'd3, d3);
    pulse_start(5'd4);
    run_seq(5, 1, -1, 4'd0, 32'd0);
    checks++;
    if (n_ls !== 2) begin errors++; $display("FAIL abort_point: got n_ls=%0d want 2", n_ls); end
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: got busy=%b aborted=%b done=%b want 0 1 0", busy, aborted, done);
    end
    bad = 0;
    repeat (10) begin step(); if (done || weight_load_req || layer_start || busy) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1) begin
      errors++; $display("FAIL abort_idle: got busy=%b aborted=%b want 0 1", busy, aborted);
    end
    num_layers = 5'd4; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || aborted !== 1'b0 || cur_layer !== 4'd0) begin
      errors++; $display("FAIL abort_restart: got busy=%b aborted=%b cur=%0d want 1 0 0", busy, aborted, cur_layer);
    end
    run_seq(2, -1, -1, 4'd0, 32'd0);
    checks++;
    if (n_done !== 1 || n_ls !== 4 || rec_fields[3] !== d3[30:0]) begin
      errors++; $display("FAIL abort_rerun: got done=%0d n_ls=%0d f3=%h want 1 4 %h",
                         n_done, n_ls, rec_fields[3], d3[30:0]);
    end
    step();
  endtask

  task automatic test_no_stall();
    int wl_at, ls_at, ls2_at, nw, nl, done_at;
    nw = 0; nl = 0; done_at = -1; wl_at = -1; ls_at = -1; ls2_at = -1;
    write_weight_finish = 1'b1; layer_finish = 1'b1;
    pulse_start(5'd2);
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      if (weight_load_req) begin if (nw == 0) wl_at = c; nw++; end
      if (layer_start) begin if (nl == 0) ls_at = c; else ls2_at = c; nl++; end
      if (done) done_at = c;
      step();
    end
    write_weight_finish = 1'b0; layer_finish = 1'b0;
    checks++;
    if (wl_at !== 1 || ls_at !== 3) begin
      errors++; $display("FAIL nostall_first: got wl@%0d ls@%0d want 1 3", wl_at, ls_at);
    end
    checks++;
    if (ls2_at !== 9 || done_at !== 12) begin
      errors++; $display("FAIL nostall_latency: got ls2@%0d done@%0d want 9 12", ls2_at, done_at);
    end
  endtask

  task automatic test_clamp();
    pulse_start(5'd31);
    run_seq(1, -1, -1, 4'd0, 32'd0);
    checks++;
    if (n_ls !== 16 || n_wl !== 16 || n_done !== 1 || rec_cur[15] !== 4'd15) begin
      errors++; $display("FAIL clamp: got ls=%0d wl=%0d done=%0d last=%0d want 16 16 1 15",
                         n_ls, n_wl, n_done, rec_cur[15]);
    end
    step();
  endtask

  task automatic test_rst_mid();
    pulse_start(5'd3);
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || cur_layer !== 4'd0 || operation !== 2'd0 || input_channel_size !== 12'd0) begin
      errors++; $display("FAIL rst_mid: got busy=%b cur=%0d op=%0d ic=%0d want 0 0 0 0",
                         busy, cur_layer, operation, input_channel_size);
    end
    pulse_start(5'd1);
    run_seq(2, -1, -1, 4'd0, 32'd0);
    checks++;
    if (n_done !== 1 || rec_fields[0] !== d0[30:0]) begin
      errors++; $display("FAIL rst_retain: got done=%0d f0=%h want 1 %h", n_done, rec_fields[0], d0[30:0]);
    end
    step();
  endtask

  task automatic test_wait_bound();
    int ls_c;
    ls_c = -1;
    write_weight_finish = 1'b1;
    pulse_start(5'd1);
    for (int c = 0; c < 20 && ls_c < 0; c++) begin
      if (layer_start) ls_c = c; else step();
    end
    write_weight_finish = 1'b0;
    checks++;
    if (ls_c < 0) begin errors++; $display("FAIL wait_bound_launch: got no layer_start want 1"); end
`ifdef LAYER_SEQ_TIMEOUT_EN
    repeat (100) step();
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got timeout=%b busy=%b want 0 1", timeout, busy);
    end
    step();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: got timeout=%b busy=%b aborted=%b want 1 0 0",
                         timeout, busy, aborted);
    end
`else
    repeat (1000) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL no_timeout: got busy=%b want 1", busy); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL no_timeout_abort: got busy=%b want 0", busy); end
`endif
  endtask

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0; num_layers = '0;
    start = 1'b0; abort = 1'b0; write_weight_finish = 1'b0; layer_finish = 1'b0;
    d0 = mk_desc(1, 3, 64, 128);
    d1 = mk_desc(2, 5, 128, 256);
    d2 = mk_desc(0, 1, 256, 10);
    d3 = mk_desc(3, 7, 32, 4095);
    d1_new = mk_desc(3, 9, 1, 2);
    step();
    test_reset();
    test_basic();
    test_zero_layers();
    test_write_while_busy();
    test_abort();
    test_no_stall();
    test_clamp();
    test_rst_mid();
    test_wait_bound();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
